// File: rtl/led_driver_pkg.sv
// Shared types and constants for the LED chain serializer.
// Holds the FSM state encoding, the default chain length and a counter-width helper.
package led_driver_pkg;

    localparam int LED_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_GAP   = 2'd3
    } ledState_t;

    // Bits needed for a counter that runs 0..n-1. Never narrower than one bit.
    function automatic int ctrWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_driver_shift_reg.sv
// Shadow register for one LED frame: parallel load, then presents bits MSB-first.
// The register rotates rather than shifts so every stored bit stays in use.
module led_shift_reg
    import led_driver_pkg::*;
#(
    parameter int DATA_WIDTH = LED_WIDTH
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET,
    input  logic                  i_Load,
    input  logic                  i_Shift,
    input  logic [DATA_WIDTH-1:0] i_Data,
    output logic                  o_NextBit
);

    logic [DATA_WIDTH-1:0] r_Shadow;

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_Shadow <= '0;
        end else if (i_Load) begin
            r_Shadow <= i_Data;
        end else if (i_Shift) begin
            r_Shadow <= {r_Shadow[DATA_WIDTH-2:0], r_Shadow[DATA_WIDTH-1]};
        end
    end

    // The MSB is sent straight from the input at load time, so the next bit is one below it.
    assign o_NextBit = r_Shadow[DATA_WIDTH-2];

endmodule

// File: rtl/led_driver.sv
// Free-running serializer feeding a 74HC595-style LED chain: load, shift MSB-first,
// one-cycle latch strobe, optional idle gap, repeat.
module led_driver
    import led_driver_pkg::*;
#(
    parameter int DATA_WIDTH = LED_WIDTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET,
    input  logic [DATA_WIDTH-1:0] i_Data16,
    output logic                  o_LEDData,
    output logic                  o_LEDLatch
);

    localparam int CNT_W = ctrWidth(DATA_WIDTH);
    localparam int GAP_W = ctrWidth(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    ledState_t        r_State;
    logic [CNT_W-1:0] r_Cnt;
    logic [GAP_W-1:0] r_Gap;
    logic             r_Data;
    logic             r_Latch;

    ledState_t        w_StateNext;
    logic [CNT_W-1:0] w_CntNext;
    logic [GAP_W-1:0] w_GapNext;
    logic             w_DataNext;
    logic             w_LatchNext;
    logic             w_Load;
    logic             w_Shift;
    logic             w_NextBit;

    led_shift_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shift (
        .i_CLK    (i_CLK),
        .i_RESET  (i_RESET),
        .i_Load   (w_Load),
        .i_Shift  (w_Shift),
        .i_Data   (i_Data16),
        .o_NextBit(w_NextBit)
    );

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_State <= ST_LOAD;
            r_Cnt   <= '0;
            r_Gap   <= '0;
            r_Data  <= 1'b0;
            r_Latch <= 1'b0;
        end else begin
            r_State <= w_StateNext;
            r_Cnt   <= w_CntNext;
            r_Gap   <= w_GapNext;
            r_Data  <= w_DataNext;
            r_Latch <= w_LatchNext;
        end
    end

    // Data defaults to 0 so the line is low in every non-shift cycle, including the strobe.
    always_comb begin
        w_StateNext = r_State;
        w_CntNext   = r_Cnt;
        w_GapNext   = r_Gap;
        w_DataNext  = 1'b0;
        w_LatchNext = 1'b0;
        w_Load      = 1'b0;
        w_Shift     = 1'b0;

        case (r_State)
            ST_LOAD: begin
                w_Load = 1'b1;
            end
            ST_SHIFT: begin
                if (r_Cnt != CNT_LAST) begin
                    w_CntNext  = r_Cnt + 1'b1;
                    w_DataNext = w_NextBit;
                    w_Shift    = 1'b1;
                end else begin
                    w_LatchNext = 1'b1;
                    w_StateNext = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (GAP_CYCLES == 0) begin
                    w_Load = 1'b1;
                end else begin
                    w_GapNext   = '0;
                    w_StateNext = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_Gap == GAP_LAST) begin
                    w_Load = 1'b1;
                end else begin
                    w_GapNext = r_Gap + 1'b1;
                end
            end
            default: begin
                w_StateNext = ST_LOAD;
            end
        endcase

        // Loading is shared by LOAD, a zero-gap LATCH and the last GAP cycle.
        if (w_Load) begin
            w_DataNext  = i_Data16[DATA_WIDTH-1];
            w_CntNext   = '0;
            w_GapNext   = '0;
            w_StateNext = ST_SHIFT;
        end
    end

    assign o_LEDData  = r_Data;
    assign o_LEDLatch = r_Latch;

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: two instances (no gap and a 3-cycle gap)
// checked every cycle against a frame-phase reference model and a model 595 register.
module tb_led_driver;

    localparam int P0 = 17;
    localparam int P3 = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data0;
    logic [15:0] data3;
    logic        ledData0, ledLatch0, ledData3, ledLatch3;

    int assertCount = 0;
    int failCount   = 0;

    int          k0, k3;
    logic [15:0] frame0, frame3;

    logic [15:0] sr0, sr3, latched0, latched3;
    int          latchCount0 = 0;
    int          latchCount3 = 0;
    int          savedCount0, savedCount3;

    always #5 clk = ~clk;

    led_driver #(.DATA_WIDTH(16), .GAP_CYCLES(0)) dut0 (
        .i_CLK     (clk),
        .i_RESET   (rst),
        .i_Data16  (data0),
        .o_LEDData (ledData0),
        .o_LEDLatch(ledLatch0)
    );

    led_driver #(.DATA_WIDTH(16), .GAP_CYCLES(3)) dut3 (
        .i_CLK     (clk),
        .i_RESET   (rst),
        .i_Data16  (data3),
        .o_LEDData (ledData3),
        .o_LEDLatch(ledLatch3)
    );

    // External 595 model: shift clock is inverted i_CLK, storage clock is the strobe.
    always @(negedge clk) begin
        sr0 <= {sr0[14:0], ledData0};
        sr3 <= {sr3[14:0], ledData3};
    end

    always @(posedge ledLatch0) begin
        latched0 = sr0;
        latchCount0++;
    end

    always @(posedge ledLatch3) begin
        latched3 = sr3;
        latchCount3++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs after edge k of a frame sequence: 16 data bits, a strobe, then idle.
    task automatic expectOut(input int k, input int period, input logic [15:0] frame,
                             output logic expData, output logic expLatch);
        int phase;
        phase    = k % period;
        expData  = (phase < 16) ? frame[15 - phase] : 1'b0;
        expLatch = (phase == 16);
    endtask

    task automatic applyStimulus(input int nCycles, input bit randData);
        logic eD, eL;
        for (int c = 0; c < nCycles; c++) begin
            if (randData) begin
                if ($urandom_range(0, 3) == 0) data0 = 16'($urandom);
                if ($urandom_range(0, 3) == 0) data3 = 16'($urandom);
            end
            if (!rst) begin
                if (k0 % P0 == 0) frame0 = data0;
                if (k3 % P3 == 0) frame3 = data3;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                checkOutput("rstData0", 32'(ledData0), 32'd0);
                checkOutput("rstLatch0", 32'(ledLatch0), 32'd0);
                checkOutput("rstData3", 32'(ledData3), 32'd0);
                checkOutput("rstLatch3", 32'(ledLatch3), 32'd0);
            end else begin
                expectOut(k0, P0, frame0, eD, eL);
                checkOutput("data0", 32'(ledData0), 32'(eD));
                checkOutput("latch0", 32'(ledLatch0), 32'(eL));
                expectOut(k3, P3, frame3, eD, eL);
                checkOutput("data3", 32'(ledData3), 32'(eD));
                checkOutput("latch3", 32'(ledLatch3), 32'(eL));
                k0++;
                k3++;
            end
        end
    endtask

    task automatic releaseReset();
        rst = 1'b0;
        k0  = 0;
        k3  = 0;
    endtask

    task automatic assertResetNow();
        rst = 1'b1;
        #1;
        checkOutput("asyncData0", 32'(ledData0), 32'd0);
        checkOutput("asyncLatch0", 32'(ledLatch0), 32'd0);
        checkOutput("asyncData3", 32'(ledData3), 32'd0);
        checkOutput("asyncLatch3", 32'(ledLatch3), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        data0 = 16'h9D1F;
        data3 = 16'h0000;
        k0    = 0;
        k3    = 0;

        $display("[TB] reset hold");
        applyStimulus(10, 1'b0);
        checkOutput("noLatchInReset0", 32'(latchCount0), 32'd0);

        $display("[TB] basic frame");
        releaseReset();
        applyStimulus(17, 1'b0);
        checkOutput("basic595", 32'(latched0), 32'h9D1F);
        checkOutput("basicCount", 32'(latchCount0), 32'd1);
        data3 = 16'hFFFF;

        $display("[TB] continuous refresh");
        applyStimulus(34, 1'b0);
        checkOutput("refreshCount", 32'(latchCount0), 32'd3);
        checkOutput("refresh595", 32'(latched0), 32'h9D1F);
        data3 = 16'h8001;

        $display("[TB] mid-frame data change");
        applyStimulus(5, 1'b0);
        data0 = 16'h0001;
        applyStimulus(12, 1'b0);
        checkOutput("midOld595", 32'(latched0), 32'h9D1F);
        applyStimulus(17, 1'b0);
        checkOutput("midNew595", 32'(latched0), 32'h0001);
        checkOutput("gapCount", 32'(latchCount3), 32'd4);
        checkOutput("gap595", 32'(latched3), 32'h8001);

        $display("[TB] reset mid-frame");
        #2;
        assertResetNow();
        applyStimulus(2, 1'b0);
        releaseReset();
        applyStimulus(9, 1'b0);
        #2;
        savedCount0 = latchCount0;
        savedCount3 = latchCount3;
        assertResetNow();
        applyStimulus(3, 1'b0);
        checkOutput("abortNoLatch0", 32'(latchCount0), 32'(savedCount0));
        checkOutput("abortNoLatch3", 32'(latchCount3), 32'(savedCount3));
        releaseReset();
        applyStimulus(20, 1'b0);
        checkOutput("restartCount0", 32'(latchCount0), 32'(savedCount0 + 1));
        checkOutput("restart595", 32'(latched0), 32'h0001);
        checkOutput("restartCount3", 32'(latchCount3), 32'(savedCount3 + 1));

        $display("[TB] randomized data and reset pulses");
        for (int r = 0; r < 8; r++) begin
            applyStimulus(int'($urandom_range(20, 90)), 1'b1);
            #2;
            assertResetNow();
            applyStimulus(int'($urandom_range(1, 3)), 1'b1);
            releaseReset();
        end
        applyStimulus(60, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
